trace_dump: RTL
===============

TRACE_DUMP -- requirements
Module: trace_dump

Interface
REQ-001 Parameter AW, default 9, SHALL set the RAM address width; depth is 2**AW samples.
REQ-002 Parameter DW, default 8, SHALL set the sample width per channel.
REQ-003 clk  input  1  SHALL be the system clock; all logic is rising-edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 dump_start  input  1  SHALL be a one-cycle request to dump one channel's trace.
REQ-006 dump_chan  input  2  SHALL select the channel: 0=CH1, 1=CH2, 2=CH3; 3 is illegal.
REQ-007 capture_done  input  1  SHALL indicate that a complete trace is held in RAM.
REQ-008 trace_end  input  AW  SHALL be the address of the last-written sample.
REQ-009 ram_addr  output  AW  SHALL be the read address shared by all three channel RAMs.
REQ-010 ram_en  output  1  SHALL be the read enable; data is valid one clk after ram_en.
REQ-011 rdata_ch1, rdata_ch2, rdata_ch3  input  DW each  SHALL be the per-channel read data.
REQ-012 tx_data  output  DW  SHALL be the byte presented to the UART transmitter.
REQ-013 tx_start  output  1  SHALL be a one-cycle transmit strobe.
REQ-014 tx_done  input  1  SHALL be a one-cycle pulse marking the end of the current byte.
REQ-015 dump_busy  output  1  SHALL be high while a dump is in progress.
REQ-016 dump_done  output  1  SHALL be a one-cycle pulse when the last byte completes.
REQ-017 dump_err  output  1  SHALL be a one-cycle pulse when a request is rejected.
REQ-018 clr_capture_done  output  1  SHALL pulse for one cycle, coincident with dump_done.

Function
REQ-019 The FSM SHALL have the states IDLE, READ, LATCH, SEND, WAIT_TX and FINISH.
REQ-020 In IDLE, on dump_start with capture_done=1 and dump_chan!=3, the block SHALL load rd_ptr=trace_end+1 (mod 2**AW), clear a byte counter, latch dump_chan, and go to READ.
REQ-021 In IDLE, on dump_start with capture_done=0 or dump_chan=3, the block SHALL pulse dump_err next cycle and stay in IDLE.
REQ-022 In READ, ram_en SHALL be 1 with ram_addr=rd_ptr for exactly one cycle, then the FSM SHALL go to LATCH.
REQ-023 In LATCH, tx_data SHALL register the selected rdata_chN, then the FSM SHALL go to SEND.
REQ-024 In SEND, tx_start SHALL pulse for one cycle, then the FSM SHALL go to WAIT_TX.
REQ-025 tx_data SHALL stay stable from SEND until tx_done.
REQ-026 In WAIT_TX, on tx_done: if byte count equals 2**AW-1, go to FINISH; otherwise increment rd_ptr (wrapping 2**AW-1 to 0), increment the byte count, and go to READ.
REQ-027 In FINISH, dump_done and clr_capture_done SHALL pulse for one cycle, then the FSM SHALL return to IDLE.
REQ-028 Exactly 2**AW bytes SHALL be sent, oldest first; the final address SHALL equal trace_end.
REQ-029 dump_busy SHALL be 1 in every state except IDLE.
REQ-030 dump_start while busy SHALL be ignored, with no dump_err.
REQ-031 tx_done outside WAIT_TX SHALL be ignored.
REQ-032 capture_done changing mid-dump SHALL NOT affect the dump.
REQ-033 The byte counter SHALL be AW+1 bits wide; rd_ptr SHALL be AW bits and wrap naturally.
REQ-034 Latency SHALL be 3 clk from dump_start to the first ram_en and 2 clk from ram_en to tx_start.

Reset
REQ-035 On rst_n low, state SHALL be IDLE and rd_ptr=0, and all of the following SHALL be 0: ram_addr, ram_en, tx_data, tx_start, dump_busy, dump_done, dump_err, clr_capture_done.
REQ-036 A reset mid-dump SHALL abort the dump immediately, with no dump_done and no clr_capture_done.

Structure
REQ-037 The state enum and channel codes (CH1=0, CH2=1, CH3=2) SHALL live in the shared package dso_pkg.
REQ-038 No sub-module SHALL be used; the counters and FSM are internal to trace_dump.

Verification
REQ-039 trace_end=0x1FF, capture_done=1, chan=0, tx_done 10 clk after each tx_start -> addresses 0x000..0x1FF in order, 512 tx_start pulses, one dump_done and one clr_capture_done.
REQ-040 trace_end=0x0FF, chan=2 -> first ram_addr 0x100, wrap 0x1FF->0x000, last ram_addr 0x0FF, tx_data equals rdata_ch3 at each address.
REQ-041 dump_start with capture_done=0, then with chan=3 -> one dump_err pulse each, ram_en never asserted, dump_busy stays 0.
REQ-042 Second dump_start at byte 5, plus spurious tx_done in READ -> no restart, no error, byte sequence unchanged.
REQ-043 rst_n low at byte 100 -> all outputs 0 within the reset, no dump_done; a new dump_start afterwards begins at trace_end+1.
REQ-044 Latency check: dump_start at cycle t -> ram_en at t+3, tx_start at t+5.

Source files
------------

// File: rtl/dso_pkg.sv
// Shared definitions for the scope capture/dump blocks: dump FSM states and channel codes.
package dso_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    SEND,
    WAIT_TX,
    FINISH
  } dump_state_e;

  localparam logic [1:0] CH1 = 2'd0;
  localparam logic [1:0] CH2 = 2'd1;
  localparam logic [1:0] CH3 = 2'd2;

  function automatic logic chan_valid(input logic [1:0] chan);
    return chan != 2'd3;
  endfunction

endpackage

// File: rtl/trace_dump.sv
// Streams one channel of the circular capture RAM out over the UART, oldest
// sample first, one byte per tx_start/tx_done handshake.
module trace_dump
  import dso_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dump_start,
  input  logic [1:0]    dump_chan,
  input  logic          capture_done,
  input  logic [AW-1:0] trace_end,
  output logic [AW-1:0] ram_addr,
  output logic          ram_en,
  input  logic [DW-1:0] rdata_ch1,
  input  logic [DW-1:0] rdata_ch2,
  input  logic [DW-1:0] rdata_ch3,
  output logic [DW-1:0] tx_data,
  output logic          tx_start,
  input  logic          tx_done,
  output logic          dump_busy,
  output logic          dump_done,
  output logic          dump_err,
  output logic          clr_capture_done
);

  localparam logic [AW:0] LAST_BYTE = {1'b0, {AW{1'b1}}};

  dump_state_e   state, state_nxt;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   byte_cnt;
  logic [1:0]    chan_r;
  logic          start_q, cap_q;
  logic [1:0]    chan_q;
  logic          accept, last_byte;

  function automatic logic [DW-1:0] pick_sample(input logic [1:0] chan,
                                                input logic [DW-1:0] s1,
                                                input logic [DW-1:0] s2,
                                                input logic [DW-1:0] s3);
    case (chan)
      CH2:     return s2;
      CH3:     return s3;
      default: return s1;
    endcase
  endfunction

  assign accept    = (state == IDLE) && start_q && cap_q && chan_valid(chan_q);
  assign last_byte = (byte_cnt == LAST_BYTE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    state_nxt = LATCH;
      LATCH:   state_nxt = SEND;
      SEND:    state_nxt = WAIT_TX;
      WAIT_TX: if (tx_done) state_nxt = last_byte ? FINISH : READ;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request stage: the request is registered once before IDLE acts on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= 1'b0;
      chan_q   <= 2'd0;
      cap_q    <= 1'b0;
      dump_err <= 1'b0;
    end else begin
      start_q  <= dump_start && (state == IDLE);
      chan_q   <= dump_chan;
      cap_q    <= capture_done;
      dump_err <= (state == IDLE) && dump_start && !(capture_done && chan_valid(dump_chan));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      byte_cnt <= '0;
      chan_r   <= CH1;
    end else if (accept) begin
      rd_ptr   <= trace_end + AW'(1);
      byte_cnt <= '0;
      chan_r   <= chan_q;
    end else if ((state == WAIT_TX) && tx_done && !last_byte) begin
      rd_ptr   <= rd_ptr + AW'(1);
      byte_cnt <= byte_cnt + (AW+1)'(1);
    end
  end

  // Output stage: RAM read issued while in LATCH, data captured on leaving SEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en   <= 1'b0;
      ram_addr <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      ram_en   <= (state == READ);
      tx_start <= (state == SEND);
      if (state == READ) ram_addr <= rd_ptr;
      if (state == SEND) tx_data  <= pick_sample(chan_r, rdata_ch1, rdata_ch2, rdata_ch3);
    end
  end

  assign dump_busy        = (state != IDLE);
  assign dump_done        = (state == FINISH);
  assign clr_capture_done = (state == FINISH);

endmodule
